vmips_trace_monitor: RTL and testbench

Parametrised, synthesizable run-monitor for the vector MIPS core. It snoops vector-register writebacks across LANES lanes and records each one as a PC-stamped entry in a circular trace buffer. It detects program end (fetched instruction == 0), drains for a programmable number of cycles, and raises a sticky `done`. Benches and on-chip debug logic read the trace through a valid/ready port, without reaching into register-file internals.

---
 rtl/vmips_trace_monitor.sv | 162 ++++++++++++++++
 tb/tb_vmips_trace_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmips_trace_monitor.sv
// rtl/vmips_trace_monitor.sv - vector writeback trace monitor with run/halt detection
//
// Purpose: records every vector-register writeback seen while the core is
// running (and while draining after halt) as a {pc, addr, data} entry in a
// circular trace buffer, and raises a sticky done once the run has ended.
//
// Build option: define VMIPS_TRACE_PC_EN to store the PC per entry; when it is
// undefined no PC storage exists and trace_pc reads 32'd0.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   inst, pc             fetched instruction and its PC (inst == 0 is halt)
//   wb_en/addr/data      vector writeback snoop, lane 0 in the LSBs
//   trace_valid/ready    show-ahead head entry handshake
//   trace_pc/addr/data   head entry fields
//   count                entries held
//   overflow, drop_cnt   sticky overwrite flag, saturating overwrite count
//   cycles               edges spent in RUN or DRAIN (wraps)
//   done                 sticky end-of-run flag

module vmips_trace_monitor #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               inst,
  input  logic [31:0]               pc,
  input  logic                      wb_en,
  input  logic [REG_AW-1:0]         wb_addr,
  input  logic [LANES*DATA_W-1:0]   wb_data,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [31:0]               trace_pc,
  output logic [REG_AW-1:0]         trace_addr,
  output logic [LANES*DATA_W-1:0]   trace_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  output logic [31:0]               cycles,
  output logic                      done
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DCW = $clog2(DRAIN_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;
  logic [31:0]      cycles_q, cycles_d;

  logic [LANES*DATA_W-1:0] data_mem_q [DEPTH];
  logic [REG_AW-1:0]       addr_mem_q [DEPTH];

  logic active, push, pop, full;

  // Capture window covers RUN (including the cycle halt is seen) and DRAIN.
  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign push   = active & wb_en;
  assign full   = (count_q == CW'(DEPTH));
  assign pop    = trace_valid & trace_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (inst != 32'd0) state_d = S_RUN;
      S_RUN: begin
        if (inst == 32'd0) begin
          state_d = S_DRAIN;
          drain_d = DCW'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    cycles_d   = active ? cycles_q + 32'd1 : cycles_q;
    if (push) wptr_d = wptr_q + 1'b1;
    // A push into a full buffer without a pop evicts the oldest entry.
    if (pop || (push && full)) rptr_d = rptr_q + 1'b1;
    if (push && !pop && !full)      count_d = count_q + 1'b1;
    else if (pop && !push)          count_d = count_q - 1'b1;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      drain_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      cycles_q   <= cycles_d;
    end
  end

  // Storage is deliberately not reset; trace_valid gates its use.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wptr_q] <= wb_data;
      addr_mem_q[wptr_q] <= wb_addr;
    end
  end

`ifdef VMIPS_TRACE_PC_EN
  logic [31:0] pc_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) pc_mem_q[wptr_q] <= pc;
  end

  assign trace_pc = pc_mem_q[rptr_q];
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign trace_pc  = 32'd0;
`endif

  assign trace_valid = (count_q != '0);
  assign trace_data  = data_mem_q[rptr_q];
  assign trace_addr  = addr_mem_q[rptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_q;
  assign cycles      = cycles_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_vmips_trace_monitor.sv
// tb/tb_vmips_trace_monitor.sv - self-checking bench for vmips_trace_monitor
module tb_vmips_trace_monitor;

  localparam int DEPTH = 16;
  localparam int DRAIN = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  inst, pc;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic         trace_valid, trace_ready;
  logic [31:0]  trace_pc;
  logic [4:0]   trace_addr;
  logic [127:0] trace_data;
  logic [4:0]   count;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic [31:0]  cycles;
  logic         done;

  always #5 clk = ~clk;

  vmips_trace_monitor #(.LANES(4), .DATA_W(32), .REG_AW(5), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .cycles(cycles), .done(done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]  pc;
    logic [4:0]   addr;
    logic [127:0] data;
  } ent_t;

  typedef struct {
    logic [31:0]  inst;
    logic         wb_en;
    logic [4:0]   addr;
    logic [127:0] data;
    int           exp_count;
    logic         exp_done;
    int           exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lanes4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] exp_pc(input logic [31:0] p);
`ifdef VMIPS_TRACE_PC_EN
    return p;
`else
    return 32'd0 & p;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst = 0; pc = 0; wb_en = 0; wb_addr = 0; wb_data = 0; trace_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #10;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wb(input int n, input logic rdy);
    inst = 32'h1;
    wb_en = 1'b1;
    wb_addr = n[4:0];
    wb_data = lanes4(n, n + 100, n + 200, n + 300);
    pc = 32'h2000 + 4 * n;
    trace_ready = rdy;
    step();
  endtask

  task automatic chk_head(input string name, input int n);
    chk({name, "_data"}, trace_data, lanes4(n, n + 100, n + 200, n + 300));
    chk({name, "_addr"}, trace_addr, n[4:0]);
    chk({name, "_pc"}, trace_pc, exp_pc(32'h2000 + 4 * n));
  endtask

  vec_t tbl[8];
  ent_t q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    #10;
    chk("rst_count", count, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset-to-halt run; row 0 is an IDLE writeback that must be ignored.
    tbl[0] = '{32'h0,         1'b1, 5'd9, 128'hFF,               0, 1'b0, 0};
    tbl[1] = '{32'h2400_0001, 1'b0, 5'd0, 128'h0,                0, 1'b0, 0};
    tbl[2] = '{32'h2400_0002, 1'b1, 5'd1, lanes4(1, 2, 3, 4),    1, 1'b0, 1};
    tbl[3] = '{32'h2400_0003, 1'b1, 5'd2, lanes4(5, 6, 7, 8),    2, 1'b0, 2};
    tbl[4] = '{32'h2400_0004, 1'b1, 5'd3, lanes4(6, 8, 10, 12),  3, 1'b0, 3};
    tbl[5] = '{32'h0,         1'b0, 5'd0, 128'h0,                3, 1'b0, 4};
    tbl[6] = '{32'h0,         1'b0, 5'd0, 128'h0,                3, 1'b0, 5};
    tbl[7] = '{32'h0,         1'b0, 5'd0, 128'h0,                3, 1'b1, 6};
    for (int i = 0; i < 8; i++) begin
      inst = tbl[i].inst; wb_en = tbl[i].wb_en; wb_addr = tbl[i].addr;
      wb_data = tbl[i].data; pc = 32'h1000 + 4 * i; trace_ready = 1'b0;
      step();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_valid", i), trace_valid, tbl[i].exp_count != 0);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_cycles", i), cycles, tbl[i].exp_cycles);
    end
    wb_en = 1'b0; trace_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("run_head%0d_data", k), trace_data, tbl[k + 2].data);
      chk($sformatf("run_head%0d_addr", k), trace_addr, tbl[k + 2].addr);
      chk($sformatf("run_head%0d_pc", k), trace_pc, exp_pc(32'h1000 + 4 * (k + 2)));
      step();
    end
    chk("run_empty_count", count, 0);
    chk("run_empty_valid", trace_valid, 0);
    chk("run_done_sticky", done, 1);
    chk("run_cycles_frozen", cycles, 6);

    // Capture gating around halt and in DONE.
    do_reset();
    inst = 1; step();
    inst = 1; wb_en = 1; wb_addr = 1; wb_data = 128'h11; step();
    chk("gate_run_count", count, 1);
    inst = 0; wb_en = 1; wb_addr = 2; wb_data = 128'h22; step();
    chk("gate_haltcyc_count", count, 2);
    wb_en = 0; step(); step();
    chk("gate_done", done, 1);
    inst = 5; wb_en = 1; wb_addr = 3; wb_data = 128'h33; step();
    chk("gate_done_count", count, 2);
    chk("gate_done_stays", done, 1);
    chk("gate_head_addr", trace_addr, 1);

    // Simultaneous push and pop while full.
    do_reset();
    inst = 1; step();
    for (int n = 0; n < DEPTH; n++) wb(n, 1'b0);
    chk("full_count", count, DEPTH);
    chk("full_overflow", overflow, 0);
    wb(16, 1'b1);
    chk("pushpop_count", count, DEPTH);
    chk("pushpop_overflow", overflow, 0);
    chk("pushpop_drop", drop_cnt, 0);
    wb_en = 0; trace_ready = 0;
    chk_head("pushpop_head", 1);

    // Overflow: 20 writebacks with no consumer.
    do_reset();
    inst = 1; step();
    for (int n = 0; n < 20; n++) wb(n, 1'b0);
    wb_en = 0;
    chk("ovf_count", count, DEPTH);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_drop", drop_cnt, 4);
    chk_head("ovf_head", 4);
    trace_ready = 1;
    for (int n = 4; n < 20; n++) begin
      chk_head($sformatf("ovf_drain%0d", n), n);
      step();
    end
    chk("ovf_empty_valid", trace_valid, 0);

    // Mid-run asynchronous reset.
    do_reset();
    inst = 1; step();
    for (int n = 0; n < 5; n++) wb(n, 1'b0);
    chk("mid_count", count, 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", trace_valid, 0);
    chk("mid_rst_cycles", cycles, 0);
    chk("mid_rst_done", done, 0);

    // Randomized run against a queue model.
    begin
      int start_e, halt_e, cyc, drops;
      logic ovf, active, pushm, popm;
      do_reset();
      q.delete();
      start_e = -1; halt_e = -1; cyc = 0; drops = 0; ovf = 0;
      for (int i = 0; i < 400; i++) begin
        int e;
        e = i + 1;
        if (i < 3)        inst = 0;
        else if (i < 260) inst = $urandom | 32'h1;
        else              inst = (i % 3 == 0) ? 32'h7 : 32'h0;
        pc = $urandom;
        wb_en = $urandom_range(0, 1);
        wb_addr = $urandom;
        wb_data = {$urandom, $urandom, $urandom, $urandom};
        trace_ready = (i >= 100 && i < 160) ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (start_e >= 0 && halt_e < 0 && inst == 0) halt_e = e;
        active = (start_e >= 0) && (halt_e < 0 || e <= halt_e + DRAIN);
        if (start_e < 0 && inst != 0) start_e = e;
        pushm = active && wb_en;
        popm = (q.size() != 0) && trace_ready;
        if (popm) void'(q.pop_front());
        if (pushm) begin
          if (q.size() == DEPTH) begin
            void'(q.pop_front());
            ovf = 1;
            if (drops < 65535) drops++;
          end
          q.push_back('{pc, wb_addr, wb_data});
        end
        if (active) cyc++;
        step();
        chk($sformatf("rnd%0d_count", i), count, q.size());
        chk($sformatf("rnd%0d_valid", i), trace_valid, q.size() != 0);
        chk($sformatf("rnd%0d_overflow", i), overflow, ovf);
        chk($sformatf("rnd%0d_drop", i), drop_cnt, drops);
        chk($sformatf("rnd%0d_cycles", i), cycles, cyc);
        chk($sformatf("rnd%0d_done", i), done, (halt_e >= 0) && (e >= halt_e + DRAIN));
        if (q.size() != 0) begin
          chk($sformatf("rnd%0d_data", i), trace_data, q[0].data);
          chk($sformatf("rnd%0d_addr", i), trace_addr, q[0].addr);
          chk($sformatf("rnd%0d_pc", i), trace_pc, exp_pc(q[0].pc));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
